block_ram_true_dual_mixed_be: RTL and testbench

Mixed-width true dual-port block RAM with per-lane byte enables, per-port enables, a selectable read-during-write mode and an optional output pipeline stage.
Each port has a VALID response strobe, so downstream logic can track read latency without counting cycles.
It is the drop-in successor for wide/narrow buffers, for example a scalar-lane port A against a vector-wide port B, in SIMT and cache datapaths.

---
 rtl/block_ram_true_dual_mixed_be.sv | 185 ++++++++++++++++++
 tb/tb_block_ram_true_dual_mixed_be.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/block_ram_true_dual_mixed_be.sv
// Mixed-width true dual-port RAM: narrow port A, wide port B, lane enables, VALID strobes.
// Optional COLLIDE_A/COLLIDE_B outputs are compiled in with `define BLOCKRAM_TDM_COLLIDE_EN.
module block_ram_true_dual_mixed_be #(
    parameter int DATA_WIDTH_A = 32,
    parameter int ADDR_WIDTH_A = 10,
    parameter int ADDR_WIDTH_B = 8,
    parameter int LANE_WIDTH   = 8,
    parameter int READ_MODE    = 0,
    parameter int OUT_REG      = 0,
    parameter     INIT_FILE    = "",
    localparam int RATIO        = 1 << (ADDR_WIDTH_A - ADDR_WIDTH_B),
    localparam int DATA_WIDTH_B = DATA_WIDTH_A * RATIO,
    localparam int LANES_A      = DATA_WIDTH_A / LANE_WIDTH,
    localparam int LANES_B      = LANES_A * RATIO
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    EN_A,
    input  logic                    WE_A,
    input  logic [LANES_A-1:0]      BE_A,
    input  logic [ADDR_WIDTH_A-1:0] ADDR_A,
    input  logic [DATA_WIDTH_A-1:0] DI_A,
    output logic [DATA_WIDTH_A-1:0] DO_A,
    output logic                    VALID_A,
    input  logic                    EN_B,
    input  logic                    WE_B,
    input  logic [LANES_B-1:0]      BE_B,
    input  logic [ADDR_WIDTH_B-1:0] ADDR_B,
    input  logic [DATA_WIDTH_B-1:0] DI_B,
    output logic [DATA_WIDTH_B-1:0] DO_B,
    output logic                    VALID_B
`ifdef BLOCKRAM_TDM_COLLIDE_EN
    ,
    output logic                    COLLIDE_A,
    output logic                    COLLIDE_B
`endif
);
    localparam int SUB_W  = ADDR_WIDTH_A - ADDR_WIDTH_B;
    localparam int SUB_W1 = (SUB_W > 0) ? SUB_W : 1;

    logic [DATA_WIDTH_B-1:0] mem [0:(1 << ADDR_WIDTH_B)-1];

    function automatic logic [DATA_WIDTH_B-1:0] lane_merge(
        input logic [DATA_WIDTH_B-1:0] old_w,
        input logic [DATA_WIDTH_B-1:0] new_w,
        input logic [LANES_B-1:0]      be
    );
        logic [DATA_WIDTH_B-1:0] r;
        r = old_w;
        for (int i = 0; i < LANES_B; i++) begin
            if (be[i]) r[i*LANE_WIDTH +: LANE_WIDTH] = new_w[i*LANE_WIDTH +: LANE_WIDTH];
        end
        return r;
    endfunction

    logic [ADDR_WIDTH_B-1:0] word_a;
    logic [SUB_W1-1:0]       sub_a;

    generate
        if (SUB_W > 0) begin : g_sub
            assign word_a = ADDR_A[ADDR_WIDTH_A-1:SUB_W];
            assign sub_a  = ADDR_A[SUB_W-1:0];
        end else begin : g_nosub
            assign word_a = ADDR_A;
            assign sub_a  = '0;
        end
    endgenerate

    logic [DATA_WIDTH_B-1:0] old_a, old_b, di_a_full, own_a, own_b, new_a, new_b;
    logic [LANES_B-1:0]      be_a_full;
    logic [DATA_WIDTH_A-1:0] do_a_d;
    logic [DATA_WIDTH_B-1:0] do_b_d;
    logic                    wr_a, wr_b, same_word;

    always_comb begin
        old_a     = mem[word_a];
        old_b     = mem[ADDR_B];
        di_a_full = {RATIO{DI_A}};
        be_a_full = LANES_B'(BE_A) << (sub_a * LANES_A);
        wr_a      = EN_A & WE_A;
        wr_b      = EN_B & WE_B;
        same_word = (word_a == ADDR_B);
        own_a     = lane_merge(old_a, di_a_full, be_a_full);
        own_b     = lane_merge(old_b, DI_B, BE_B);
        // Same-word double write: both ports compute the identical merged word, B on top.
        new_a     = (same_word && wr_b) ? lane_merge(own_a, DI_B, BE_B) : own_a;
        new_b     = (same_word && wr_a) ? lane_merge(lane_merge(old_b, di_a_full, be_a_full), DI_B, BE_B)
                                        : own_b;
        do_a_d    = (WE_A && READ_MODE == 0) ? own_a[sub_a*DATA_WIDTH_A +: DATA_WIDTH_A]
                                             : old_a[sub_a*DATA_WIDTH_A +: DATA_WIDTH_A];
        do_b_d    = (WE_B && READ_MODE == 0) ? own_b : old_b;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (wr_a) mem[word_a] <= new_a;
            if (wr_b) mem[ADDR_B] <= new_b;
        end
    end

    logic                    vld_a_q, vld_b_q;
    logic [DATA_WIDTH_A-1:0] do_a_q;
    logic [DATA_WIDTH_B-1:0] do_b_q;

    // First response stage: DO only updates on an accepted request.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            vld_a_q <= 1'b0;
            vld_b_q <= 1'b0;
            do_a_q  <= '0;
            do_b_q  <= '0;
        end else begin
            vld_a_q <= EN_A;
            vld_b_q <= EN_B;
            if (EN_A) do_a_q <= do_a_d;
            if (EN_B) do_b_q <= do_b_d;
        end
    end

`ifdef BLOCKRAM_TDM_COLLIDE_EN
    logic col_d, col_a_q, col_b_q;
    assign col_d = EN_A & EN_B & same_word & (WE_A | WE_B);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            col_a_q <= 1'b0;
            col_b_q <= 1'b0;
        end else begin
            col_a_q <= col_d;
            col_b_q <= col_d;
        end
    end
`endif

    generate
        if (OUT_REG != 0) begin : g_out
            logic                    vld2_a_q, vld2_b_q;
            logic [DATA_WIDTH_A-1:0] do2_a_q;
            logic [DATA_WIDTH_B-1:0] do2_b_q;

            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    vld2_a_q <= 1'b0;
                    vld2_b_q <= 1'b0;
                    do2_a_q  <= '0;
                    do2_b_q  <= '0;
                end else begin
                    vld2_a_q <= vld_a_q;
                    vld2_b_q <= vld_b_q;
                    if (vld_a_q) do2_a_q <= do_a_q;
                    if (vld_b_q) do2_b_q <= do_b_q;
                end
            end

            assign DO_A    = do2_a_q;
            assign DO_B    = do2_b_q;
            assign VALID_A = vld2_a_q;
            assign VALID_B = vld2_b_q;
`ifdef BLOCKRAM_TDM_COLLIDE_EN
            logic col2_a_q, col2_b_q;
            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    col2_a_q <= 1'b0;
                    col2_b_q <= 1'b0;
                end else begin
                    col2_a_q <= col_a_q;
                    col2_b_q <= col_b_q;
                end
            end
            assign COLLIDE_A = col2_a_q;
            assign COLLIDE_B = col2_b_q;
`endif
        end else begin : g_direct
            assign DO_A    = do_a_q;
            assign DO_B    = do_b_q;
            assign VALID_A = vld_a_q;
            assign VALID_B = vld_b_q;
`ifdef BLOCKRAM_TDM_COLLIDE_EN
            assign COLLIDE_A = col_a_q;
            assign COLLIDE_B = col_b_q;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_block_ram_true_dual_mixed_be.sv
// Scoreboard bench: two instances (write-first/latency 1 and read-first/latency 2) share one stimulus stream.
module tb_block_ram_true_dual_mixed_be;
    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic         EN_A = 1'b0, WE_A = 1'b0, EN_B = 1'b0, WE_B = 1'b0;
    logic [3:0]   BE_A = '0;
    logic [9:0]   ADDR_A = '0;
    logic [31:0]  DI_A = '0;
    logic [15:0]  BE_B = '0;
    logic [7:0]   ADDR_B = '0;
    logic [127:0] DI_B = '0;
    logic [31:0]  DO_A0, DO_A1;
    logic [127:0] DO_B0, DO_B1;
    logic         VALID_A0, VALID_A1, VALID_B0, VALID_B1;
    logic         COLLIDE_A0, COLLIDE_A1, COLLIDE_B0, COLLIDE_B1;

    always #5 CLK = ~CLK;

    block_ram_true_dual_mixed_be #(.READ_MODE(0), .OUT_REG(0)) dut0 (
        .CLK(CLK), .RESET(RESET),
        .EN_A(EN_A), .WE_A(WE_A), .BE_A(BE_A), .ADDR_A(ADDR_A), .DI_A(DI_A), .DO_A(DO_A0), .VALID_A(VALID_A0),
        .EN_B(EN_B), .WE_B(WE_B), .BE_B(BE_B), .ADDR_B(ADDR_B), .DI_B(DI_B), .DO_B(DO_B0), .VALID_B(VALID_B0)
`ifdef BLOCKRAM_TDM_COLLIDE_EN
        , .COLLIDE_A(COLLIDE_A0), .COLLIDE_B(COLLIDE_B0)
`endif
    );

    block_ram_true_dual_mixed_be #(.READ_MODE(1), .OUT_REG(1)) dut1 (
        .CLK(CLK), .RESET(RESET),
        .EN_A(EN_A), .WE_A(WE_A), .BE_A(BE_A), .ADDR_A(ADDR_A), .DI_A(DI_A), .DO_A(DO_A1), .VALID_A(VALID_A1),
        .EN_B(EN_B), .WE_B(WE_B), .BE_B(BE_B), .ADDR_B(ADDR_B), .DI_B(DI_B), .DO_B(DO_B1), .VALID_B(VALID_B1)
`ifdef BLOCKRAM_TDM_COLLIDE_EN
        , .COLLIDE_A(COLLIDE_A1), .COLLIDE_B(COLLIDE_B1)
`endif
    );

`ifndef BLOCKRAM_TDM_COLLIDE_EN
    assign COLLIDE_A0 = 1'b0;
    assign COLLIDE_A1 = 1'b0;
    assign COLLIDE_B0 = 1'b0;
    assign COLLIDE_B1 = 1'b0;
`endif

    typedef struct {
        logic [127:0] exp;
        logic [127:0] mask;
        int           cyc;
        bit           col;
    } exp_t;

    exp_t qa0[$], qa1[$], qb0[$], qb1[$];
    int   ntests = 0;
    int   nfail  = 0;
    int   ecnt   = 0;

    localparam logic [31:0]  M32 = 32'hFFFF_FFFF;
    localparam logic [127:0] L64 = 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF;
    localparam logic [127:0] W1  = 128'h0000_0000_0000_0000_FFFF_FFFF_0000_0000;

    always @(posedge CLK) ecnt <= ecnt + 1;

    task automatic chk(input string nm, input logic [127:0] got, input logic got_col, input exp_t e);
        ntests++;
        if ((((got ^ e.exp) & e.mask) !== 128'd0) || (ecnt != e.cyc)) begin
            nfail++;
            $display("FAIL %s: got %h at cycle %0d, required %h (mask %h) at cycle %0d",
                     nm, got, ecnt, e.exp, e.mask, e.cyc);
        end
`ifdef BLOCKRAM_TDM_COLLIDE_EN
        ntests++;
        if (got_col !== e.col) begin
            nfail++;
            $display("FAIL %s_collide: got %b, required %b", nm, got_col, e.col);
        end
`else
        if (got_col !== 1'b0) $display("note: collide tie-off %b", got_col);
`endif
    endtask

    task automatic unexpected(input string nm);
        ntests++;
        nfail++;
        $display("FAIL %s: VALID got 1 at cycle %0d, required 0 (no request pending)", nm, ecnt);
    endtask

    always @(negedge CLK) begin
        if (VALID_A0) begin
            if (qa0.size() == 0) unexpected("dut0_A");
            else chk("dut0_A", {96'd0, DO_A0}, COLLIDE_A0, qa0.pop_front());
        end
        if (VALID_A1) begin
            if (qa1.size() == 0) unexpected("dut1_A");
            else chk("dut1_A", {96'd0, DO_A1}, COLLIDE_A1, qa1.pop_front());
        end
        if (VALID_B0) begin
            if (qb0.size() == 0) unexpected("dut0_B");
            else chk("dut0_B", DO_B0, COLLIDE_B0, qb0.pop_front());
        end
        if (VALID_B1) begin
            if (qb1.size() == 0) unexpected("dut1_B");
            else chk("dut1_B", DO_B1, COLLIDE_B1, qb1.pop_front());
        end
    end

    task automatic chk_zero(input string nm, input logic [127:0] got);
        ntests++;
        if (got !== 128'd0) begin
            nfail++;
            $display("FAIL %s: got %h, required 0", nm, got);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk_zero({tag, "_valid_a0"}, {127'd0, VALID_A0});
        chk_zero({tag, "_valid_b0"}, {127'd0, VALID_B0});
        chk_zero({tag, "_valid_a1"}, {127'd0, VALID_A1});
        chk_zero({tag, "_valid_b1"}, {127'd0, VALID_B1});
        chk_zero({tag, "_do_a0"}, {96'd0, DO_A0});
        chk_zero({tag, "_do_b0"}, DO_B0);
        chk_zero({tag, "_do_a1"}, {96'd0, DO_A1});
        chk_zero({tag, "_do_b1"}, DO_B1);
`ifdef BLOCKRAM_TDM_COLLIDE_EN
        chk_zero({tag, "_collide"}, {124'd0, COLLIDE_A0, COLLIDE_B0, COLLIDE_A1, COLLIDE_B1});
`endif
    endtask

    task automatic step();
        @(negedge CLK);
        EN_A = 1'b0; WE_A = 1'b0; BE_A = '0; ADDR_A = '0; DI_A = '0;
        EN_B = 1'b0; WE_B = 1'b0; BE_B = '0; ADDR_B = '0; DI_B = '0;
    endtask

    task automatic a_op(input bit we, input logic [3:0] be, input logic [9:0] addr, input logic [31:0] di,
                        input logic [31:0] e0, input logic [31:0] m0,
                        input logic [31:0] e1, input logic [31:0] m1, input bit col);
        EN_A = 1'b1; WE_A = we; BE_A = be; ADDR_A = addr; DI_A = di;
        qa0.push_back('{exp: {96'd0, e0}, mask: {96'd0, m0}, cyc: ecnt + 1, col: col});
        qa1.push_back('{exp: {96'd0, e1}, mask: {96'd0, m1}, cyc: ecnt + 2, col: col});
    endtask

    task automatic b_op(input bit we, input logic [15:0] be, input logic [7:0] addr, input logic [127:0] di,
                        input logic [127:0] e0, input logic [127:0] m0,
                        input logic [127:0] e1, input logic [127:0] m1, input bit col);
        EN_B = 1'b1; WE_B = we; BE_B = be; ADDR_B = addr; DI_B = di;
        qb0.push_back('{exp: e0, mask: m0, cyc: ecnt + 1, col: col});
        qb1.push_back('{exp: e1, mask: m1, cyc: ecnt + 2, col: col});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 RESET = 1'b1;
        #1 chk_all_zero("reset");
        repeat (2) @(negedge CLK);
        RESET = 1'b0;

        // Narrow write, wide read of the containing word.
        step(); a_op(1, 4'hF, 10'd5, 32'hDEADBEEF, 32'hDEADBEEF, M32, 32'h0, 32'h0, 0);
        step(); b_op(0, 16'h0, 8'd1, 128'd0, {64'd0, 32'hDEADBEEF, 32'd0}, W1, {64'd0, 32'hDEADBEEF, 32'd0}, W1, 0);
        // Wide write, then lane-masked narrow write and read back.
        step(); b_op(1, 16'h00FF, 8'd0, 128'h0011223344556677, 128'h0011223344556677, L64, 128'd0, 128'd0, 0);
        step(); a_op(1, 4'b0101, 10'd0, 32'hAABBCCDD, 32'h44BB66DD, M32, 32'h44556677, M32, 0);
        step(); a_op(0, 4'h0, 10'd0, 32'd0, 32'h44BB66DD, M32, 32'h44BB66DD, M32, 0);
        // Read-during-write mode and BE=0 no-op write.
        step(); a_op(1, 4'hF, 10'd2, 32'h11111111, 32'h11111111, M32, 32'h0, 32'h0, 0);
        step(); a_op(1, 4'hF, 10'd2, 32'h22222222, 32'h22222222, M32, 32'h11111111, M32, 0);
        step(); a_op(1, 4'h0, 10'd2, 32'h33333333, 32'h22222222, M32, 32'h22222222, M32, 0);
        step(); a_op(0, 4'h0, 10'd2, 32'd0, 32'h22222222, M32, 32'h22222222, M32, 0);
        // Same-cycle overlapping writes: B wins lane 0.
        step();
        a_op(1, 4'h1, 10'd0, 32'h000000AA, 32'h44BB66AA, M32, 32'h44BB66DD, M32, 1);
        b_op(1, 16'h0001, 8'd0, 128'hFF, 128'h0011223344BB66FF, L64, 128'h0011223344BB66DD, L64, 1);
        // Cross-port: B reads the word A is writing and sees the old contents.
        step();
        a_op(1, 4'hF, 10'd1, 32'h12345678, 32'h12345678, M32, 32'h00112233, M32, 1);
        b_op(0, 16'h0, 8'd0, 128'd0, 128'h0011223344BB66FF, L64, 128'h0011223344BB66FF, L64, 1);
        step(); a_op(0, 4'h0, 10'd0, 32'd0, 32'h44BB66FF, M32, 32'h44BB66FF, M32, 0);
        step(); b_op(0, 16'h0, 8'd0, 128'd0, 128'h1234567844BB66FF, L64, 128'h1234567844BB66FF, L64, 0);
        // Back-to-back reads, a gap, then more reads.
        step(); a_op(0, 4'h0, 10'd0, 32'd0, 32'h44BB66FF, M32, 32'h44BB66FF, M32, 0);
        step(); a_op(0, 4'h0, 10'd1, 32'd0, 32'h12345678, M32, 32'h12345678, M32, 0);
        step(); a_op(0, 4'h0, 10'd2, 32'd0, 32'h22222222, M32, 32'h22222222, M32, 0);
        step();
        step();
        step(); a_op(0, 4'h0, 10'd5, 32'd0, 32'hDEADBEEF, M32, 32'hDEADBEEF, M32, 0);
        step(); a_op(0, 4'h0, 10'd2, 32'd0, 32'h22222222, M32, 32'h22222222, M32, 0);

        // Reset with a read still in the latency-2 pipe.
        step(); a_op(0, 4'h0, 10'd5, 32'd0, 32'hDEADBEEF, M32, 32'hDEADBEEF, M32, 0);
        step();
        #2 RESET = 1'b1;
        #1 chk_all_zero("async_reset");
        qa0.delete(); qa1.delete(); qb0.delete(); qb1.delete();
        EN_A = 1'b1; WE_A = 1'b1; BE_A = 4'hF; ADDR_A = 10'd5; DI_A = 32'd0;
        EN_B = 1'b1; WE_B = 1'b1; BE_B = 16'hFFFF; ADDR_B = 8'd1; DI_B = 128'd0;
        step();
        chk_all_zero("held_reset");
        RESET = 1'b0;
        step();
        a_op(0, 4'h0, 10'd5, 32'd0, 32'hDEADBEEF, M32, 32'hDEADBEEF, M32, 0);
        b_op(0, 16'h0, 8'd1, 128'd0, {64'd0, 32'hDEADBEEF, 32'd0}, W1, {64'd0, 32'hDEADBEEF, 32'd0}, W1, 0);
        step(); a_op(0, 4'h0, 10'd2, 32'd0, 32'h22222222, M32, 32'h22222222, M32, 0);
        step();
        repeat (4) @(negedge CLK);

        ntests++;
        if ((qa0.size() + qa1.size() + qb0.size() + qb1.size()) != 0) begin
            nfail++;
            $display("FAIL drain: got %0d responses outstanding, required 0",
                     qa0.size() + qa1.size() + qb0.size() + qb1.size());
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
